// File: rtl/q_maze_pkg.sv
// Shared constants for the grid-maze Q-learning episode sequencer:
// action encodings, FSM state codes, LFSR tap mask and a width helper.
package q_maze_pkg;

   // Grid moves; row = s / GRID_W, col = s % GRID_W.
   localparam logic [1:0] ACT_UP    = 2'd0;
   localparam logic [1:0] ACT_DOWN  = 2'd1;
   localparam logic [1:0] ACT_LEFT  = 2'd2;
   localparam logic [1:0] ACT_RIGHT = 2'd3;

   // Episode FSM state codes.
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START_CHK = 3'd1;
   localparam logic [2:0] ST_SELECT    = 3'd2;
   localparam logic [2:0] ST_MOVE      = 3'd3;
   localparam logic [2:0] ST_UPDATE    = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

   // Right-shifting Galois feedback mask for taps 16,14,13,11.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Bits needed to index n_states states (at least one bit).
   function automatic int state_w(input int n_states);
      return (n_states > 1) ? $clog2(n_states) : 1;
   endfunction

endpackage

// File: rtl/q_lfsr16.sv
// 16-bit Galois LFSR used for epsilon-greedy exploration.
// Advances by one position on each cycle where adv is high.
module q_lfsr16
   import q_maze_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        adv,
   output logic [15:0] lfsr
);

   // Shift right; when the bit leaving at the bottom is 1, fold in the taps.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= SEED;
      end else if (adv) begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      end
   end

endmodule

// File: rtl/q_episode_controller.sv
// Episode sequencer for grid-maze Q-learning. Each step picks an action
// (random or agent-greedy), proposes the grid move, asks the maze whether
// the target is blocked, and offers the (s, a, s', r) tuple to the agent.
//
// Update handshake: upd_valid rises together with a registered tuple and
// the tuple is held unchanged until a cycle where upd_valid & upd_ready
// (with en high) is seen at a rising edge; that edge is the transfer and
// upd_valid drops in the following cycle. upd_ready may toggle freely.
module q_episode_controller
   import q_maze_pkg::*;
#(
   parameter int          GRID_W      = 5,
   parameter int          GRID_H      = 5,
   parameter int          START_STATE = 0,
   parameter int          GOAL_STATE  = 24,
   parameter int          MAX_STEPS   = 64,
   parameter int          REWARD_W    = 16,
   parameter int          EPS_W       = 8,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   localparam int         STATE_W     = state_w(GRID_W * GRID_H),
   localparam int         STEP_W      = $clog2(MAX_STEPS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                start,
   input  logic [EPS_W-1:0]    epsilon,
   input  logic [1:0]          greedy_action,
   input  logic                maze_blocked,
   input  logic [REWARD_W-1:0] reward,
   input  logic                upd_ready,
   output logic [STATE_W-1:0]  cur_state,
   output logic [STATE_W-1:0]  cand_state,
   output logic                upd_valid,
   output logic [STATE_W-1:0]  upd_state,
   output logic [1:0]          upd_action,
   output logic [STATE_W-1:0]  upd_next_state,
   output logic [REWARD_W-1:0] upd_reward,
   output logic                upd_explore,
   output logic                busy,
   output logic                episode_done,
   output logic                goal,
   output logic                timeout,
   output logic                error,
   output logic [STEP_W-1:0]   step_cnt,
   output logic [15:0]         episode_cnt,
   output logic [2:0]          state_dbg
);

   logic [2:0]         state;
   logic [15:0]        lfsr;
   logic               lfsr_adv;
   logic               lfsr_unused;
   logic               sel_explore;
   logic [1:0]         sel_action;
   logic [STATE_W-1:0] nbr_state;

   // Random source only moves while choosing an action.
   assign lfsr_adv = en && (state == ST_SELECT);

   q_lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .adv  (lfsr_adv),
      .lfsr (lfsr)
   );

   // Bits above the compare field and action field are not consumed.
   assign lfsr_unused = ^(lfsr >> (EPS_W + 2));

   // Epsilon-greedy choice from the pre-advance LFSR value.
   assign sel_explore = (lfsr[EPS_W-1:0] < epsilon);
   assign sel_action  = sel_explore ? lfsr[EPS_W+1:EPS_W] : greedy_action;

   // Neighbour of cur_state under the registered action; off-grid stays put.
   always_comb begin
      int cur_i;
      int row_i;
      int col_i;
      int nbr_i;
      cur_i = int'(cur_state);
      row_i = cur_i / GRID_W;
      col_i = cur_i % GRID_W;
      nbr_i = cur_i;
      case (upd_action)
         ACT_UP:    if (row_i > 0)          nbr_i = cur_i - GRID_W;
         ACT_DOWN:  if (row_i < GRID_H - 1) nbr_i = cur_i + GRID_W;
         ACT_LEFT:  if (col_i > 0)          nbr_i = cur_i - 1;
         default:   if (col_i < GRID_W - 1) nbr_i = cur_i + 1;
      endcase
      nbr_state = STATE_W'(nbr_i);
   end

   // The maze sees the current state while checking the start, else the move target.
   assign cand_state = (state == ST_MOVE) ? nbr_state : cur_state;
   assign busy       = (state != ST_IDLE);
   assign state_dbg  = state;

   // Episode FSM with its datapath registers; en low freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         cur_state      <= STATE_W'(START_STATE);
         upd_valid      <= 1'b0;
         upd_state      <= '0;
         upd_action     <= '0;
         upd_next_state <= '0;
         upd_reward     <= '0;
         upd_explore    <= 1'b0;
         episode_done   <= 1'b0;
         goal           <= 1'b0;
         timeout        <= 1'b0;
         error          <= 1'b0;
         step_cnt       <= '0;
         episode_cnt    <= '0;
      end else if (en) begin
         episode_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cur_state <= STATE_W'(START_STATE);
                  step_cnt  <= '0;
                  goal      <= 1'b0;
                  timeout   <= 1'b0;
                  error     <= 1'b0;
                  state     <= ST_START_CHK;
               end
            end
            ST_START_CHK: begin
               if (maze_blocked) begin
                  error        <= 1'b1;
                  episode_done <= 1'b1;
                  state        <= ST_IDLE;
               end else begin
                  state <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               upd_action  <= sel_action;
               upd_explore <= sel_explore;
               state       <= ST_MOVE;
            end
            ST_MOVE: begin
               upd_state      <= cur_state;
               upd_next_state <= maze_blocked ? cur_state : nbr_state;
               upd_reward     <= reward;
               upd_valid      <= 1'b1;
               state          <= ST_UPDATE;
            end
            ST_UPDATE: begin
               if (upd_ready) begin
                  upd_valid <= 1'b0;
                  cur_state <= upd_next_state;
                  step_cnt  <= step_cnt + STEP_W'(1);
                  if (upd_next_state == STATE_W'(GOAL_STATE)) begin
                     goal         <= 1'b1;
                     episode_done <= 1'b1;
                     state        <= ST_DONE;
                  end else if (step_cnt == STEP_W'(MAX_STEPS - 1)) begin
                     timeout      <= 1'b1;
                     episode_done <= 1'b1;
                     state        <= ST_DONE;
                  end else begin
                     state <= ST_SELECT;
                  end
               end
            end
            ST_DONE: begin
               episode_cnt <= episode_cnt + 16'd1;
               state       <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_q_episode_controller.sv
// Bench for q_episode_controller on a 5x5 grid with an 8-step limit.
// A reference model predicts every update tuple and the episode outcome
// when an episode is launched; a monitor compares tuples on transfer.
module tb_q_episode_controller;
   import q_maze_pkg::*;

   localparam int GW    = 5;
   localparam int GH    = 5;
   localparam int START = 0;
   localparam int GOAL  = 24;
   localparam int MAXS  = 8;
   localparam int RW    = 16;
   localparam int EW    = 8;
   localparam int SW    = 5;
   localparam int STW   = 4;
   localparam int TW    = SW + 2 + SW + RW + 1;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk;
   logic          rst;
   logic          en;
   logic          start;
   logic [EW-1:0] epsilon;
   logic [1:0]    greedy_action;
   logic          maze_blocked;
   logic [RW-1:0] reward;
   logic          upd_ready;
   logic [SW-1:0] cur_state;
   logic [SW-1:0] cand_state;
   logic          upd_valid;
   logic [SW-1:0] upd_state;
   logic [1:0]    upd_action;
   logic [SW-1:0] upd_next_state;
   logic [RW-1:0] upd_reward;
   logic          upd_explore;
   logic          busy;
   logic          episode_done;
   logic          goal;
   logic          timeout;
   logic          error;
   logic [STW-1:0] step_cnt;
   logic [15:0]   episode_cnt;
   logic [2:0]    state_dbg;

   // environment knobs
   int         policy_mode;   // 0: constant greedy_const, 1: right along row 0 then down
   logic [1:0] greedy_const;
   int         wall_mode;     // 0: open, 1: state 1 blocked, 2: state 0 blocked

   // scoreboard and model state
   logic [TW-1:0] exp_q[$];
   logic [15:0]   m_lfsr;
   logic [15:0]   m_ep_cnt;
   logic          exp_goal;
   logic          exp_timeout;
   logic          exp_error;
   int            exp_steps;
   int            n_total;
   int            n_bad;
   int            n_steps;
   int            n_explore;

   q_episode_controller #(
      .GRID_W      (GW),
      .GRID_H      (GH),
      .START_STATE (START),
      .GOAL_STATE  (GOAL),
      .MAX_STEPS   (MAXS),
      .REWARD_W    (RW),
      .EPS_W       (EW),
      .LFSR_SEED   (SEED)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .start          (start),
      .epsilon        (epsilon),
      .greedy_action  (greedy_action),
      .maze_blocked   (maze_blocked),
      .reward         (reward),
      .upd_ready      (upd_ready),
      .cur_state      (cur_state),
      .cand_state     (cand_state),
      .upd_valid      (upd_valid),
      .upd_state      (upd_state),
      .upd_action     (upd_action),
      .upd_next_state (upd_next_state),
      .upd_reward     (upd_reward),
      .upd_explore    (upd_explore),
      .busy           (busy),
      .episode_done   (episode_done),
      .goal           (goal),
      .timeout        (timeout),
      .error          (error),
      .step_cnt       (step_cnt),
      .episode_cnt    (episode_cnt),
      .state_dbg      (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- maze / agent environment ----------------
   assign greedy_action = (policy_mode == 1)
                          ? (((int'(cur_state) % GW) < GW - 1) ? 2'd3 : 2'd1)
                          : greedy_const;
   assign maze_blocked  = (wall_mode == 1 && cand_state == 5'd1) ||
                          (wall_mode == 2 && cand_state == 5'd0);
   assign reward        = maze_blocked ? 16'hFFFB
                          : ((cand_state == 5'd24) ? 16'd100 : 16'hFFFF);

   // ---------------- reference model ----------------
   function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
      logic [15:0] n;
      n = {1'b0, v[15:1]};
      if (v[0]) begin
         n[15] = ~n[15];
         n[13] = ~n[13];
         n[12] = ~n[12];
         n[10] = ~n[10];
      end
      return n;
   endfunction

   function automatic int ref_move(input int s, input logic [1:0] a);
      int r;
      int c;
      r = s / GW;
      c = s % GW;
      case (a)
         2'd0: r = (r == 0) ? r : r - 1;
         2'd1: r = (r == GH - 1) ? r : r + 1;
         2'd2: c = (c == 0) ? c : c - 1;
         default: c = (c == GW - 1) ? c : c + 1;
      endcase
      return r * GW + c;
   endfunction

   function automatic logic ref_blocked(input int c);
      return (wall_mode == 1 && c == 1) || (wall_mode == 2 && c == 0);
   endfunction

   function automatic logic [1:0] ref_policy(input int s);
      if (policy_mode == 1) return ((s % GW) < GW - 1) ? 2'd3 : 2'd1;
      return greedy_const;
   endfunction

   task automatic model_episode();
      int         s;
      int         c;
      int         nx;
      logic       blk;
      logic       ex;
      logic [1:0] a;
      logic [RW-1:0] r;
      s = START;
      exp_goal = 1'b0;
      exp_timeout = 1'b0;
      exp_error = 1'b0;
      exp_steps = 0;
      if (ref_blocked(s)) begin
         exp_error = 1'b1;
         return;
      end
      for (int k = 0; k < MAXS; k++) begin
         ex = (m_lfsr[EW-1:0] < epsilon);
         a = ex ? m_lfsr[EW+1:EW] : ref_policy(s);
         m_lfsr = ref_lfsr(m_lfsr);
         c = ref_move(s, a);
         blk = ref_blocked(c);
         nx = blk ? s : c;
         r = blk ? 16'hFFFB : ((c == GOAL) ? 16'd100 : 16'hFFFF);
         exp_q.push_back({SW'(s), a, SW'(nx), r, ex});
         exp_steps++;
         s = nx;
         if (s == GOAL) begin
            exp_goal = 1'b1;
            break;
         end
         if (exp_steps == MAXS) begin
            exp_timeout = 1'b1;
            break;
         end
      end
      m_ep_cnt = m_ep_cnt + 16'd1;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // tuple monitor: a transfer happens at the next rising edge
   always begin
      @(negedge clk);
      #1;
      if (rst === 1'b0 && en === 1'b1 && upd_valid === 1'b1 && upd_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            check("tuple", 32'({upd_state, upd_action, upd_next_state, upd_reward, upd_explore}),
                  32'(exp_q.pop_front()));
            n_steps++;
            if (upd_explore) n_explore++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_episode();
      @(negedge clk);
      model_episode();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (upd_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("valid_wait", 32'd0, 32'd1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (episode_done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         check("done_wait", 32'd0, 32'd1);
         return;
      end
      check("goal", 32'(goal), 32'(exp_goal));
      check("timeout", 32'(timeout), 32'(exp_timeout));
      check("error", 32'(error), 32'(exp_error));
      check("step_cnt", 32'(step_cnt), 32'(exp_steps));
      @(negedge clk);
      check("done_pulse_len", 32'(episode_done), 32'd0);
      check("episode_cnt", 32'(episode_cnt), 32'(m_ep_cnt));
      check("busy_after", 32'(busy), 32'd0);
      check("q_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_episode(input int pm, input logic [1:0] g, input int wm, input logic [EW-1:0] eps);
      policy_mode = pm;
      greedy_const = g;
      wall_mode = wm;
      epsilon = eps;
      start_episode();
      wait_done();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      n_total = 0;
      n_bad = 0;
      n_steps = 0;
      n_explore = 0;
      m_lfsr = SEED;
      m_ep_cnt = 16'd0;
      rst = 1'b1;
      en = 1'b1;
      start = 1'b0;
      epsilon = '0;
      policy_mode = 0;
      greedy_const = 2'd3;
      wall_mode = 0;
      upd_ready = 1'b1;
      repeat (3) @(negedge clk);

      // reset values
      check("rst_cur_state", 32'(cur_state), 32'(START));
      check("rst_cand_state", 32'(cand_state), 32'(START));
      check("rst_upd_valid", 32'(upd_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(episode_done), 32'd0);
      check("rst_flags", 32'({goal, timeout, error}), 32'd0);
      check("rst_step_cnt", 32'(step_cnt), 32'd0);
      check("rst_episode_cnt", 32'(episode_cnt), 32'd0);
      check("rst_tuple", 32'({upd_state, upd_action, upd_next_state, upd_reward, upd_explore}), 32'd0);
      rst = 1'b0;

      // blocked start: error, no episode counted
      run_episode(0, 2'd3, 2, 8'd0);
      // greedy right: pinned at the east wall until the step limit
      run_episode(0, 2'd3, 0, 8'd0);
      // right x4 then down x4: goal on the last allowed step wins over timeout
      run_episode(1, 2'd0, 0, 8'd0);
      // up from the top row: bump in place, no error
      run_episode(0, 2'd0, 0, 8'd0);
      // wall at state 1: every step bounces back to 0
      run_episode(0, 2'd3, 1, 8'd0);

      // agent stalls for 5 cycles on the first update; start is ignored meanwhile
      policy_mode = 1;
      wall_mode = 0;
      epsilon = 8'h80;
      upd_ready = 1'b0;
      start_episode();
      wait_valid();
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(upd_valid), 32'd1);
         check("stall_step_cnt", 32'(step_cnt), 32'd0);
         if (exp_q.size() > 0)
            check("stall_tuple", 32'({upd_state, upd_action, upd_next_state, upd_reward, upd_explore}),
                  32'(exp_q[0]));
         @(negedge clk);
      end
      start = 1'b0;
      upd_ready = 1'b1;
      wait_done();

      // en dropped while an update is offered: nothing transfers
      start_episode();
      wait_valid();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("frz_valid", 32'(upd_valid), 32'd1);
         check("frz_step_cnt", 32'(step_cnt), 32'd0);
         check("frz_cur_state", 32'(cur_state), 32'(START));
         if (exp_q.size() > 0)
            check("frz_tuple", 32'({upd_state, upd_action, upd_next_state, upd_reward, upd_explore}),
                  32'(exp_q[0]));
      end
      en = 1'b1;
      wait_done();

      // reset in the middle of an episode
      policy_mode = 0;
      greedy_const = 2'd3;
      epsilon = 8'd0;
      start_episode();
      repeat (7) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_cur_state", 32'(cur_state), 32'(START));
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(upd_valid), 32'd0);
      check("mid_rst_done", 32'(episode_done), 32'd0);
      check("mid_rst_episode_cnt", 32'(episode_cnt), 32'd0);
      exp_q.delete();
      m_lfsr = SEED;
      m_ep_cnt = 16'd0;
      rst = 1'b0;
      @(negedge clk);

      // near-always exploration over at least 1000 steps
      n_steps = 0;
      n_explore = 0;
      for (int e = 0; e < 300 && n_steps < 1000; e++) begin
         run_episode(1, 2'd0, 0, 8'hFF);
      end
      check("explore_steps", 32'(n_steps >= 1000), 32'd1);
      check("explore_rate", 32'(n_explore * 1000 >= n_steps * 980), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/q_episode_controller.md
Name: q_episode_controller

Overview:
- Parametrised episode sequencer for grid-maze Q-learning; generalises the fixed 5x5 / 4-action control unit to arbitrary grid size, step limits and an epsilon-greedy policy.
- Drives one step per iteration: selects action (random or agent-greedy), computes the grid move, queries the maze for walls, and hands the (s, a, s', r) tuple to the Q-learning agent over a valid/ready handshake.
- Reports goal, timeout and error; counts episodes.

Parameters:
- GRID_W, 5, grid columns.
- GRID_H, 5, grid rows.
- START_STATE, 0, state index loaded at episode start, row-major.
- GOAL_STATE, 24, terminal state index.
- MAX_STEPS, 64, step limit per episode, >=1.
- REWARD_W, 16, signed reward width.
- EPS_W, 8, epsilon and compare width, <=14.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global advance enable; low freezes all state, LFSR and counters.
- start  in  1  begin an episode; honoured only in IDLE.
- epsilon  in  EPS_W  exploration threshold.
- greedy_action  in  2  agent's argmax action for cur_state.
- maze_blocked  in  1  combinational maze answer for cand_state.
- reward  in  REWARD_W  combinational reward for next_state.
- upd_ready  in  1  agent accepted the update.
- cur_state  out  STATE_W  current state; STATE_W = clog2(GRID_W*GRID_H).
- cand_state  out  STATE_W  proposed move target, for the maze lookup.
- upd_valid  out  1  update tuple valid.
- upd_state, upd_action, upd_next_state, upd_reward  out  STATE_W/2/STATE_W/REWARD_W  update tuple.
- upd_explore  out  1  action was random.
- busy  out  1  FSM not in IDLE.
- episode_done  out  1  one-cycle pulse at episode end.
- goal  out  1  sticky: last episode reached GOAL_STATE.
- timeout  out  1  sticky: last episode hit MAX_STEPS.
- error  out  1  sticky: start state blocked.
- step_cnt  out  clog2(MAX_STEPS+1)  steps taken this episode.
- episode_cnt  out  16  completed episodes; wraps at 2^16.

Behaviour:
- Reset: FSM=IDLE; all outputs 0, except cur_state=START_STATE, cand_state=START_STATE; LFSR=LFSR_SEED.
- en=0: every register holds, including the FSM, LFSR and upd_valid; the update tuple stays stable.
- Actions: 0=up (row-1), 1=down (row+1), 2=left (col-1), 3=right (col+1). row=s/GRID_W, col=s%GRID_W.
- IDLE: on start&en: cur_state<=START_STATE; step_cnt<=0; clear goal, timeout and error; go START_CHK.
- START_CHK, 1 cycle: cand_state=cur_state.
  - maze_blocked=1: error<=1; episode_done pulse; back to IDLE; episode_cnt unchanged.
  - Otherwise go SELECT.
- SELECT, 1 cycle: LFSR (16-bit Galois, taps 16,14,13,11) advances once.
  - explore = lfsr[EPS_W-1:0] < epsilon, using pre-advance value.
  - Action = lfsr[EPS_W+1:EPS_W] if explore, else greedy_action.
  - Register action and explore; go MOVE.
- MOVE, 1 cycle: cand_state = neighbour; an off-grid move yields cand_state=cur_state.
  - maze_blocked=1: next_state=cur_state (bump, no error).
  - Otherwise next_state=cand_state.
  - Register next_state and reward; go UPDATE.
- UPDATE: upd_valid=1 with a stable tuple until upd_valid&upd_ready; the transfer takes 1 cycle.
  - On transfer: cur_state<=next_state; step_cnt++.
  - If next_state==GOAL_STATE: goal<=1, go DONE.
  - Else if step_cnt+1==MAX_STEPS: timeout<=1, go DONE.
  - Else go SELECT.
  - Goal has priority over timeout on the same step.
- DONE, 1 cycle: episode_done=1; episode_cnt++; go IDLE.
- Throughput: with upd_ready tied high, one step per 3 cycles.
- start outside IDLE is ignored.
- rst mid-episode: immediate return to the reset values; no episode_done pulse.
- START_STATE==GOAL_STATE: the episode still runs steps; goal is checked only on transitions.

Decomposition:
- Package q_maze_pkg: action encodings (ACT_UP..ACT_RIGHT), FSM state enum, state_w() helper, LFSR tap constant.
- One sub-module: q_lfsr16, a 16-bit Galois LFSR with seed parameter and advance enable.

Test Plan:
- epsilon=0, greedy_action=3 constant, 5x5 grid, no walls, upd_ready=1 -> states 0,1,2,3,4,4,4...; at MAX_STEPS=8, timeout=1, step_cnt=8, episode_done pulses once, episode_cnt=1.
- epsilon=0, greedy pattern R,R,R,R,D,D,D,D -> cur_state reaches 24 after 8 steps; goal=1, timeout=0, episode_done pulse.
- greedy=0 (up) at state 0 -> cand_state=0; upd_next_state=0; no error; step_cnt increments.
- maze_blocked=1 when cand_state==1, greedy=3 -> upd_next_state=0 every step.
- maze_blocked=1 during START_CHK -> error=1; episode_done pulse; episode_cnt stays 0.
- upd_ready held low 5 cycles -> upd_valid high and tuple constant for 5 cycles.
- en low mid-UPDATE -> no transfer.
- rst mid-episode -> cur_state=0, busy=0.
- epsilon=8'hFF, 1000 steps -> upd_explore ~=99.6%.
- Exploratory actions match the q_lfsr16 reference-model sequence from seed 16'hACE1.
